// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses byte commands from an RX FIFO into register-file
// reads and writes. Read responses go to a TX FIFO. Malformed commands and
// write data that never arrives raise an error pulse and a saturating error
// count. Commands are handled strictly one at a time.
`timescale 1ns/1ps
module uart_cmd_parser #(
   parameter int ADDR_W      = 3,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_empty,
   output logic              o_rx_rd,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_wr,
   input  logic              i_tx_full,
   output logic [ADDR_W-1:0] o_rwaddr,
   output logic [7:0]        o_write_data,
   output logic              o_wr_req,
   output logic              o_rd_req,
   input  logic [7:0]        i_read_data,
   output logic              o_err,
   output logic [7:0]        o_err_cnt,
   output logic              o_busy
);

   // The timer only has to hold values up to TIMEOUT_CYC-1.
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   // Command bits [6:ADDR_W] are reserved and must be zero.
   localparam logic [6:0] RSV_MASK = ~7'((1 << ADDR_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_DATA,
      S_WRITE,
      S_READ_REQ,
      S_READ_WAIT,
      S_SEND,
      S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [ADDR_W-1:0] rwaddr_q, rwaddr_d;
   logic [7:0]        write_data_q, write_data_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              rx_rd;
   logic              rsv_bad;

   assign rsv_bad = |(i_rx_data[6:0] & RSV_MASK);

   // Next-state, datapath updates and the combinational RX pop strobe.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
      state_d      = state_q;
      timer_d      = timer_q;
      rwaddr_d     = rwaddr_q;
      write_data_d = write_data_q;
      tx_data_d    = tx_data_q;
      err_cnt_d    = err_cnt_q;
      rx_rd        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!i_rx_empty) begin
               rx_rd = 1'b1;
               if (rsv_bad) begin
                  state_d = S_ERR;
               end else begin
                  rwaddr_d = i_rx_data[ADDR_W-1:0];
                  if (i_rx_data[7]) begin
                     state_d = S_GET_DATA;
                     timer_d = '0;
                  end else begin
                     state_d = S_READ_REQ;
                  end
               end
            end
         end
         S_GET_DATA: begin
            if (!i_rx_empty) begin
               rx_rd        = 1'b1;
               write_data_d = i_rx_data;
               state_d      = S_WRITE;
            end else if (timer_q == TMR_LAST) begin
               // Data byte never came: drop the write without touching the register file.
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_WRITE:     state_d = S_IDLE;
         S_READ_REQ:  state_d = S_READ_WAIT;
         S_READ_WAIT: begin
            // Register file returns data the cycle after the read request.
            tx_data_d = i_read_data;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (!i_tx_full) begin
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            if (err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any command in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         rwaddr_q     <= '0;
         write_data_q <= '0;
         tx_data_q    <= '0;
         err_cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
         state_q      <= state_d;
         timer_q      <= timer_d;
         rwaddr_q     <= rwaddr_d;
         write_data_q <= write_data_d;
         tx_data_q    <= tx_data_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // Strobes are decoded from the registered state only (glitch-free toward the register file).
   assign o_wr_req     = (state_q == S_WRITE);
   assign o_rd_req     = (state_q == S_READ_REQ);
   assign o_tx_wr      = (state_q == S_SEND) && !i_tx_full;
   assign o_err        = (state_q == S_ERR);
   assign o_busy       = (state_q != S_IDLE);
   assign o_rx_rd      = rx_rd;
   assign o_rwaddr     = rwaddr_q;
   assign o_write_data = write_data_q;
   assign o_tx_data    = tx_data_q;
   assign o_err_cnt    = err_cnt_q;

endmodule
